// File: rtl/seq_shifter_pkg.sv
// Shared types and constants for the sequential one-bit-per-clock shifter.
package seq_shifter_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int SHW_DEF   = 3;

  localparam logic DIR_LEFT   = 1'b1;
  localparam logic KIND_ARITH = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle for seq_shifter.
interface seq_shifter_if
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic             lr;
  logic             al;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             busy;

  modport master (
    output in_valid, din, shamt, lr, al, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, shamt, lr, al, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-bit shift: left, logical right or arithmetic right.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] r,
  input  logic             lr,
  input  logic             al,
  output logic [WIDTH-1:0] r_next
);
  logic signed [WIDTH-1:0] r_s;

  assign r_s = $signed(r);

  always_comb begin
    r_next = {1'b0, r[WIDTH-1:1]};
    if (lr == DIR_LEFT) begin
      r_next = {r[WIDTH-2:0], 1'b0};
    end else if (al == KIND_ARITH) begin
      r_next = $unsigned(r_s >>> 1);
    end
  end
endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: latches an operand, shifts one bit per clock, then
// holds the result until the consumer takes it.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_shifter_if.slave bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_step;
  logic [SHW-1:0]   cnt_q;
  logic             lr_q;
  logic             al_q;
  logic             accept;

  assign accept = (state_q == IDLE) && bus.in_valid;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .lr     (lr_q),
    .al     (al_q),
    .r_next (r_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = (bus.shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/mode capture at acceptance, then one step per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      cnt_q <= '0;
      lr_q  <= 1'b0;
      al_q  <= 1'b0;
    end else if (accept) begin
      r_q   <= bus.din;
      cnt_q <= bus.shamt;
      lr_q  <= bus.lr;
      al_q  <= bus.al;
    end else if (state_q == SHIFT) begin
      r_q   <= r_step;
      cnt_q <= cnt_q - SHW'(1);
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.dout      = r_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases plus randomized requests.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  seq_shifter_if #(.WIDTH(8), .SHW(3)) bus ();

  seq_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s,
                                           input logic l, input logic a);
    if (l) return 8'(d << s);
    if (a) return $unsigned($signed(d) >>> s);
    return d >> s;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timestamp model: a pending request has a result and the cycle it is due
  int         cyc     = 0;
  bit         m_pend  = 0;
  bit         m_zero  = 1;
  int         m_rdy   = 0;
  logic [7:0] m_res   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 0;
      m_zero <= 1;
    end else if (!m_pend && bus.in_valid) begin
      m_pend <= 1;
      m_zero <= 0;
      m_rdy  <= cyc + int'(bus.shamt) + 1;
      m_res  <= ref_shift(bus.din, int'(bus.shamt), bus.lr, bus.al);
    end else if (m_pend && cyc >= m_rdy && bus.out_ready) begin
      m_pend <= 0;
    end
  end

  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = m_pend && (cyc >= m_rdy);
    check("in_ready", {7'd0, bus.in_ready}, {7'd0, !m_pend});
    check("out_valid", {7'd0, bus.out_valid}, {7'd0, exp_ov});
    check("busy", {7'd0, bus.busy}, {7'd0, m_pend});
    if (exp_ov) check("dout", bus.dout, m_res);
    if (m_zero) check("dout_zero", bus.dout, 8'h00);
  end

  // Called at posedge+1 with the block idle; returns there with it idle again
  task automatic do_req(input logic [7:0] d, input logic [2:0] s, input logic l,
                        input logic a, input bit rnd_rdy,
                        output logic [7:0] res, output int lat);
    bit done;
    bus.in_valid  = 1'b1;
    bus.din       = d;
    bus.shamt     = s;
    bus.lr        = l;
    bus.al        = a;
    bus.out_ready = rnd_rdy ? 1'($urandom) : 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din      = 8'($urandom);
    bus.shamt    = 3'($urandom);
    bus.lr       = 1'($urandom);
    bus.al       = 1'($urandom);
    lat  = 0;
    res  = 'x;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (lat == 0 && bus.out_valid) begin
        lat = i + 1;
        res = bus.dout;
      end
      if (bus.out_valid && bus.out_ready) done = 1;
      @(posedge clk); #1;
      if (rnd_rdy) bus.out_ready = 1'($urandom);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: no result for din=%h shamt=%0d", d, s);
    end
  endtask

  task automatic directed(input string name, input logic [7:0] d, input logic [2:0] s,
                          input logic l, input logic a, input logic [7:0] exp,
                          input int exp_lat);
    logic [7:0] res;
    int lat;
    do_req(d, s, l, a, 1'b0, res, lat);
    check(name, res, exp);
    check({name, "_lat"}, 8'(lat), 8'(exp_lat));
  endtask

  initial begin
    logic [7:0] res, d;
    logic [2:0] s;
    logic l, a;
    int lat;
    bit seen;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.shamt     = '0;
    bus.lr        = 1'b0;
    bus.al        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", bus.dout, 8'h00);
    check("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("left3",   8'h96, 3'd3, 1'b1, 1'b0, 8'hB0, 4);
    directed("lsr3",    8'h96, 3'd3, 1'b0, 1'b0, 8'h12, 4);
    directed("asr3",    8'h96, 3'd3, 1'b0, 1'b1, 8'hF2, 4);
    directed("asr7",    8'h80, 3'd7, 1'b0, 1'b1, 8'hFF, 8);
    directed("zero",    8'h96, 3'd0, 1'b1, 1'b0, 8'h96, 1);
    directed("left7",   8'h01, 3'd7, 1'b1, 1'b1, 8'h80, 8);

    // Backpressure: result held while out_ready stays low
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.din       = 8'h5A;
    bus.shamt     = 3'd2;
    bus.lr        = 1'b1;
    bus.al        = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din      = 8'hFF;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("bp_seen", {7'd0, seen}, 8'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {7'd0, bus.out_valid}, 8'd1);
      check("bp_dout", bus.dout, 8'h68);
      check("bp_in_ready", {7'd0, bus.in_ready}, 8'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {7'd0, bus.in_ready}, 8'd1);
    check("bp_cleared", {7'd0, bus.out_valid}, 8'd0);

    // Asynchronous reset two steps into a six-step shift
    bus.in_valid = 1'b1;
    bus.din      = 8'hFF;
    bus.shamt    = 3'd6;
    bus.lr       = 1'b0;
    bus.al       = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", {7'd0, bus.busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("ar_dout", bus.dout, 8'h00);
    check("ar_valid", {7'd0, bus.out_valid}, 8'd0);
    check("ar_in_ready", {7'd0, bus.in_ready}, 8'd1);
    check("ar_busy", {7'd0, bus.busy}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    directed("post_rst", 8'hC3, 3'd5, 1'b0, 1'b1, 8'hFE, 6);

    for (int n = 0; n < 1000; n++) begin
      d = 8'($urandom);
      s = 3'($urandom);
      l = 1'($urandom);
      a = 1'($urandom);
      do_req(d, s, l, a, 1'b1, res, lat);
      check("rnd_res", res, ref_shift(d, int'(s), l, a));
      check("rnd_lat", 8'(lat), 8'(int'(s) + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle 8-bit shifter that performs the same logical/arithmetic, left/right shift-by-amount operation as the combinational barrel shifter, but one bit position per clock through a single shift register. It sits behind a valid/ready request port and in front of a valid/ready result port. Use it where area matters more than latency, or where the shift result must be registered and handshaked into sequential logic.

## Interface
- WIDTH, 8, data width in bits
- SHW, 3, shift-amount width; must satisfy 2**SHW == WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request (high only in IDLE)
- din  in  WIDTH  operand
- shamt  in  SHW  shift amount, 0..WIDTH-1
- lr  in  1  direction: 1 = left, 0 = right
- al  in  1  right-shift kind: 1 = arithmetic, 0 = logical; ignored when lr=1
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- dout  out  WIDTH  result (the shift register contents)
- busy  out  1  high in SHIFT or DONE

## Operation
- State machine: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1.
  - On in_valid&in_ready, latch din into the shift register, latch lr and al, and set cnt=shamt.
  - If shamt==0, go to DONE; otherwise go to SHIFT.
- SHIFT: each cycle applies one single-bit step:
  - left: {r[WIDTH-2:0],1'b0}
  - logical right: {1'b0,r[WIDTH-1:1]}
  - arithmetic right: {r[WIDTH-1],r[WIDTH-1:1]}
- In SHIFT, cnt decrements by one each cycle. On the step where cnt==1, go to DONE.
- DONE: out_valid=1 and dout is held stable. On out_ready go to IDLE.
- in_ready is low in DONE even if out_ready=1. There is no overlap between consecutive requests.
- Inputs din, shamt, lr and al are sampled only at acceptance. Later changes have no effect.
- The result must equal the combinational shift result for every din/shamt/lr/al combination.
- Reset (asynchronous, at any time including mid-SHIFT or in DONE) forces:
  - state=IDLE, register=0, cnt=0
  - out_valid=0, busy=0, in_ready=1, dout=0
- The pending operation is discarded; there is no partial result.

## Timing
- Acceptance edge T: the cycle where in_valid&in_ready is high.
- out_valid first rises after edge T+shamt, i.e. shamt+1 cycles after the acceptance cycle. For shamt=0 it rises in the cycle right after acceptance.
- Minimum request-to-request spacing is shamt+2 cycles: acceptance, shamt shifts, at least one DONE cycle.
- out_valid, in_ready and busy are decoded from state registers only, with no combinational path from inputs.
- dout is a direct register output, with no combinational path from din.
- out_ready held low keeps DONE indefinitely with dout unchanged.

## Structure
- Shared package holds:
  - state enum {IDLE, SHIFT, DONE}
  - direction and kind constants (DIR_LEFT=1, KIND_ARITH=1)
  - WIDTH/SHW defaults
- One sub-module, shift_step: purely combinational single-bit shifter (inputs r, lr, al; output next r). Instantiated once in the datapath.
- Top-level block holds the FSM, down-counter, operand/mode latches and handshake logic.

## Test plan
- Left shift: din=0x96, shamt=3, lr=1 -> dout=0xB0; out_valid first high 4 cycles after acceptance.
- Right shifts: din=0x96, shamt=3, lr=0.
  - al=0 -> dout=0x12
  - al=1 -> dout=0xF2
- Edge amounts:
  - din=0x80, shamt=7, lr=0, al=1 -> dout=0xFF after 8 cycles
  - din=0x96, shamt=0 -> dout=0x96 the cycle after acceptance
- Backpressure: complete any shift, then hold out_ready=0 for 5 cycles.
  - out_valid and dout stay stable; in_ready=0 throughout.
  - Raise out_ready -> IDLE next cycle; in_ready=1.
- Reset and input stability:
  - Assert rst_n=0 mid-SHIFT (din=0xFF, shamt=6, after 2 steps) -> immediately dout=0, out_valid=0, in_ready=1.
  - A new request after release completes correctly.
  - Changing din and shamt during SHIFT does not affect the result.
- Random: 1000 random din/shamt/lr/al requests with random out_ready. Every result is compared against a reference shift model and checked for latency shamt+1.
